// File: rtl/vga_frame_timer_if.sv
// vga_frame_timer_if: timing/game-strobe bundle between the VGA frame timer
// and its consumers.
//   pause      : asynchronous pause switch (consumer -> timer)
//   p_tick     : one-clk pixel strobe every CLK_DIV clks
//   x, y       : pixel / line counters
//   video_on   : visible-area flag
//   hsync/vsync: active-low sync pulses
//   frame_tick : one-clk game-update strobe per unpaused frame
//   frame_cnt  : count of issued frame_tick pulses (wraps)
//   paused     : pause state latched at frame start
interface vga_frame_timer_if;
  logic       pause;
  logic       p_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       frame_tick;
  logic [7:0] frame_cnt;
  logic       paused;

  modport master (
    input  pause,
    output p_tick, x, y, video_on, hsync, vsync, frame_tick, frame_cnt, paused
  );

  modport slave (
    output pause,
    input  p_tick, x, y, video_on, hsync, vsync, frame_tick, frame_cnt, paused
  );
endinterface

// File: rtl/vga_frame_timer.sv
// vga_frame_timer: 640x480@60 VGA timing generator with a frame-aligned,
// pausable game-update strobe.
//   clk_100MHz : block clock
//   reset      : asynchronous active-low reset
//   bus        : vga_frame_timer_if master (pause in; timing/strobes out)
// Display timing never stops; pause only gates frame_tick/frame_cnt.
module vga_frame_timer #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  vga_frame_timer_if.master bus
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS   = 10'(H_DISPLAY);
  localparam logic [9:0] Y_VIS   = 10'(V_DISPLAY);
  localparam logic [9:0] X_HS_LO = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] X_HS_HI = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] Y_VS_LO = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] Y_VS_HI = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_p_tick;
  logic [9:0]       r_x;
  logic [9:0]       r_y;
  logic             r_video_on;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_paused;
  logic             r_frame_tick;
  logic [7:0]       r_frame_cnt;

  logic [DIV_W-1:0] w_div_next;
  logic [9:0]       w_x_next;
  logic [9:0]       w_y_next;
  logic             w_frame_start;
  logic             w_tick_point;
  logic             w_issue_tick;

  always_comb begin
    w_div_next = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
    w_x_next   = r_x;
    w_y_next   = r_y;
    if (r_p_tick) begin
      if (r_x == X_LAST) begin
        w_x_next = '0;
        w_y_next = (r_y == Y_LAST) ? '0 : r_y + 10'd1;
      end else begin
        w_x_next = r_x + 10'd1;
      end
    end
    // Gated by p_tick: after reset the counters sit at (0,0) without having
    // stepped there, which must not count as a frame start.
    w_frame_start = r_p_tick && (w_x_next == '0) && (w_y_next == '0);
    w_tick_point  = r_p_tick && (w_x_next == '0) && (w_y_next == Y_VIS);
    w_issue_tick  = w_tick_point && !r_paused;
  end

  // Derived outputs are registered from the next-position values so they
  // change on the same edge as x/y.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_div      <= '0;
      r_p_tick   <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_video_on <= 1'b1;
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
    end else begin
      r_div      <= w_div_next;
      r_p_tick   <= (w_div_next == DIV_LAST);
      r_x        <= w_x_next;
      r_y        <= w_y_next;
      r_video_on <= (w_x_next < X_VIS) && (w_y_next < Y_VIS);
      r_hsync    <= !((w_x_next >= X_HS_LO) && (w_x_next <= X_HS_HI));
      r_vsync    <= !((w_y_next >= Y_VS_LO) && (w_y_next <= Y_VS_HI));
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_paused     <= 1'b0;
      r_frame_tick <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_sync1      <= bus.pause;
      r_sync2      <= r_sync1;
      if (w_frame_start) begin
        r_paused <= r_sync2;
      end
      r_frame_tick <= w_issue_tick;
      if (w_issue_tick) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign bus.p_tick     = r_p_tick;
  assign bus.x          = r_x;
  assign bus.y          = r_y;
  assign bus.video_on   = r_video_on;
  assign bus.hsync      = r_hsync;
  assign bus.vsync      = r_vsync;
  assign bus.frame_tick = r_frame_tick;
  assign bus.frame_cnt  = r_frame_cnt;
  assign bus.paused     = r_paused;

endmodule

// File: tb/tb_vga_frame_timer.sv
// tb_vga_frame_timer: a scaled-down timer (10x7 pixel frame, 3 clks/pixel)
// is checked every cycle against an arithmetic model driven by elapsed
// clocks; a default-parameter timer is checked on its first line with
// hand-computed values.
module tb_vga_frame_timer;

  localparam int unsigned D  = 3;
  localparam int unsigned HD = 4, HF = 2, HS = 2, HB = 2;
  localparam int unsigned VD = 3, VF = 1, VS = 2, VB = 1;
  localparam int unsigned HT = HD + HF + HS + HB;
  localparam int unsigned VT = VD + VF + VS + VB;
  localparam int unsigned FT = HT * VT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  vga_frame_timer_if s_if ();
  vga_frame_timer_if d_if ();

  vga_frame_timer #(
    .CLK_DIV(D), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) u_small (
    .clk_100MHz(clk),
    .reset     (rst_n),
    .bus       (s_if)
  );

  vga_frame_timer u_default (
    .clk_100MHz(clk),
    .reset     (rst_n),
    .bus       (d_if)
  );

  // ---------------- behavioural model (scaled DUT) ----------------
  int unsigned m_k;      // clock edges since reset release
  logic        m_paused;
  logic        m_tick;
  logic [7:0]  m_cnt;
  logic        ph1, ph2; // pause as seen one and two edges ago

  // True when edge k is a pixel step landing on pixel index pix of a frame.
  function automatic bit lands_on(input int unsigned k, input int unsigned pix);
    return (k > 0) && (k % D == 0) && (((k / D) % FT) == pix);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k      <= 0;
      m_paused <= 1'b0;
      m_tick   <= 1'b0;
      m_cnt    <= 8'd0;
      ph1      <= 1'b0;
      ph2      <= 1'b0;
    end else begin
      m_k <= m_k + 1;
      ph1 <= s_if.pause;
      ph2 <= ph1;
      if (lands_on(m_k + 1, 0)) m_paused <= ph2;
      m_tick <= lands_on(m_k + 1, HT * VD) && !m_paused;
      if (lands_on(m_k + 1, HT * VD) && !m_paused) m_cnt <= m_cnt + 8'd1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int unsigned p, ex, ey;
    logic e_pt, e_vo, e_hs, e_vs;
    logic [34:0] act, exp_v;
    p    = m_k / D;
    ex   = p % HT;
    ey   = (p / HT) % VT;
    e_pt = (m_k % D) == D - 1;
    e_vo = (ex < HD) && (ey < VD);
    e_hs = !((ex >= HD + HF) && (ex < HD + HF + HS));
    e_vs = !((ey >= VD + VF) && (ey < VD + VF + VS));
    act   = {s_if.x, s_if.y, s_if.p_tick, s_if.video_on, s_if.hsync, s_if.vsync,
             s_if.frame_tick, s_if.frame_cnt, s_if.paused};
    exp_v = {ex[9:0], ey[9:0], e_pt, e_vo, e_hs, e_vs, m_tick, m_cnt, m_paused};
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL model t=%0t got x=%0d y=%0d pt=%b vo=%b hs=%b vs=%b ft=%b cnt=%0d pd=%b expected x=%0d y=%0d pt=%b vo=%b hs=%b vs=%b ft=%b cnt=%0d pd=%b",
               $time, s_if.x, s_if.y, s_if.p_tick, s_if.video_on, s_if.hsync, s_if.vsync,
               s_if.frame_tick, s_if.frame_cnt, s_if.paused,
               ex, ey, e_pt, e_vo, e_hs, e_vs, m_tick, m_cnt, m_paused);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic check_rst(input string who, input logic [9:0] x, input logic [9:0] y,
                           input logic pt, input logic vo, input logic hs, input logic vs,
                           input logic ft, input logic [7:0] cnt, input logic pd);
    check({who, "_rst_x"},   32'(x),   0);
    check({who, "_rst_y"},   32'(y),   0);
    check({who, "_rst_pt"},  32'(pt),  0);
    check({who, "_rst_vo"},  32'(vo),  1);
    check({who, "_rst_hs"},  32'(hs),  1);
    check({who, "_rst_vs"},  32'(vs),  1);
    check({who, "_rst_ft"},  32'(ft),  0);
    check({who, "_rst_cnt"}, 32'(cnt), 0);
    check({who, "_rst_pd"},  32'(pd),  0);
  endtask

  task automatic wait_s_xy(input int unsigned wx, input int unsigned wy, input int unsigned budget);
    bit found = 1'b0;
    for (int unsigned i = 0; i < budget && !found; i++) begin
      @(posedge clk); #1;
      if (s_if.x == 10'(wx) && s_if.y == 10'(wy)) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wait_xy: got no (%0d,%0d) expected it within %0d clks", wx, wy, budget);
    end
  endtask

  task automatic count_ticks(input int unsigned n, output int unsigned t);
    t = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (s_if.frame_tick) t++;
    end
  endtask

  task automatic wait_tick(input int unsigned budget);
    bit found = 1'b0;
    for (int unsigned i = 0; i < budget && !found; i++) begin
      @(posedge clk); #1;
      if (s_if.frame_tick) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wait_tick: got no frame_tick expected one within %0d clks", budget);
    end
  endtask

  // Default-timing first-line expectations: x becomes n at edge 4n.
  int unsigned t_edge [10] = '{3, 4, 2559, 2560, 2623, 2624, 3007, 3008, 3199, 3200};
  int unsigned t_x    [10] = '{0, 1, 639,  640,  655,  656,  751,  752,  799,  0};
  int unsigned t_y    [10] = '{0, 0, 0,    0,    0,    0,    0,    0,    0,    1};
  logic        t_pt   [10] = '{1, 0, 1,    0,    1,    0,    1,    0,    1,    0};
  logic        t_vo   [10] = '{1, 1, 1,    0,    0,    0,    0,    0,    0,    1};
  logic        t_hs   [10] = '{1, 1, 1,    1,    1,    0,    0,    1,    1,    1};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned idx;
    int unsigned t;
    s_if.pause = 1'b0;
    d_if.pause = 1'b0;

    // Reset values
    repeat (10) @(posedge clk);
    #1;
    check_rst("d", d_if.x, d_if.y, d_if.p_tick, d_if.video_on, d_if.hsync, d_if.vsync,
              d_if.frame_tick, d_if.frame_cnt, d_if.paused);
    check_rst("s", s_if.x, s_if.y, s_if.p_tick, s_if.video_on, s_if.hsync, s_if.vsync,
              s_if.frame_tick, s_if.frame_cnt, s_if.paused);

    // First line of default timing; scaled DUT runs alongside
    @(negedge clk); #2;
    rst_n = 1'b1;
    idx = 0;
    for (int unsigned e = 1; e <= 3200; e++) begin
      @(posedge clk); #1;
      if (e == 2) check("s_first_ptick", 32'(s_if.p_tick), 1);
      if (e == 3) check("s_x_after_ptick", 32'(s_if.x), 1);
      if (idx < 10 && e == t_edge[idx]) begin
        check($sformatf("d_x@%0d",  e), 32'(d_if.x),        t_x[idx]);
        check($sformatf("d_y@%0d",  e), 32'(d_if.y),        t_y[idx]);
        check($sformatf("d_pt@%0d", e), 32'(d_if.p_tick),   32'(t_pt[idx]));
        check($sformatf("d_vo@%0d", e), 32'(d_if.video_on), 32'(t_vo[idx]));
        check($sformatf("d_hs@%0d", e), 32'(d_if.hsync),    32'(t_hs[idx]));
        check($sformatf("d_vs@%0d", e), 32'(d_if.vsync),    1);
        idx++;
      end
    end
    // Ticks land at pixel 30+70n; 1066 pixels elapsed -> 15 ticks
    check("s_cnt_after_3200", 32'(s_if.frame_cnt), 15);

    // Pause gating: set mid-frame A, clear mid-frame B
    wait_s_xy(0, 1, 400);
    s_if.pause = 1'b1;
    count_ticks(D * FT, t);
    check("pause_frameA_ticks", t, 1);
    check("pause_latched_B", 32'(s_if.paused), 1);
    s_if.pause = 1'b0;
    count_ticks(D * FT, t);
    check("pause_frameB_ticks", t, 0);
    check("pause_cleared_C", 32'(s_if.paused), 0);
    count_ticks(D * FT, t);
    check("pause_frameC_ticks", t, 1);

    // Randomized pause activity, including short pulses
    for (int i = 0; i < 40; i++) begin
      s_if.pause = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 150)) @(posedge clk);
      #3;
    end
    s_if.pause = 1'b0;

    // Reset mid-frame, mid-divide
    wait_s_xy(5, 2, 400);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_rst("s_mid", s_if.x, s_if.y, s_if.p_tick, s_if.video_on, s_if.hsync, s_if.vsync,
              s_if.frame_tick, s_if.frame_cnt, s_if.paused);
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("s_restart_x", 32'(s_if.x), 1);
    check("s_restart_y", 32'(s_if.y), 0);

    // frame_cnt wrap
    repeat (255) wait_tick(D * FT + 20);
    check("cnt_255", 32'(s_if.frame_cnt), 255);
    wait_tick(D * FT + 20);
    check("cnt_wrap_0", 32'(s_if.frame_cnt), 0);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
